// File: rtl/btn_evt_pkg.sv
// Shared event codes, FSM state encoding and small helpers for btn_event_decoder.
package btn_evt_pkg;

    localparam logic [1:0] EVT_REPEAT = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_LONG   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PRESS1   = 2'b01,
        ST_GAP      = 2'b10,
        ST_WAIT_REL = 2'b11
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A new event may load when the slot is empty or being emptied this cycle.
    function automatic logic evt_can_load(input logic valid, input logic ready);
        return (~valid) | ready;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler with a saturating ms counter; clr restarts timing and
// counts the clearing cycle as the first prescaler step of the new interval.
module ms_tick #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] ms_cnt
);

    localparam int               PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [PW-1:0]    presc_r;
    logic [CNT_W-1:0] ms_cnt_r;
    logic             wrap_s;

    assign wrap_s = (presc_r == PRESC_LAST);

    // Prescaler and saturating ms counter; ms_cnt never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r  <= {PW{1'b0}};
            ms_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            presc_r  <= PW'(1);
            ms_cnt_r <= {CNT_W{1'b0}};
        end else if (wrap_s) begin
            presc_r <= {PW{1'b0}};
            if (ms_cnt_r != CNT_MAX) begin
                ms_cnt_r <= ms_cnt_r + CNT_W'(1);
            end else begin
                ms_cnt_r <= ms_cnt_r;
            end
        end else begin
            presc_r  <= presc_r + PW'(1);
            ms_cnt_r <= ms_cnt_r;
        end
    end

    assign ms_cnt = ms_cnt_r;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button presses into SINGLE / DOUBLE / LONG events on a
// valid/ready port. Define BTN_EVT_REPEAT_EN to add auto-repeat after LONG.
module btn_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_in,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       held,
    output logic       evt_drop
);

    localparam int               MAX_MS   = max3(LONG_MS, DCLICK_MS, REPEAT_MS);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DCLICK_MS);

    generate
        if ((TICK_DIV < 2) || (longint'(MAX_MS) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
            $error("btn_event_decoder: TICK_DIV below 2 or CNT_W too narrow for the ms limits");
        end
    endgenerate

    state_t           state_r;
    state_t           next_state_s;
    logic             pin_prev_r;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] ms_cnt_s;
    logic             clr_s;
    logic             rep_clr_s;
    logic             emit_s;
    logic [1:0]       emit_code_s;
    logic             load_s;
    logic             long_hit_s;
    logic             gap_hit_s;
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_MS);
    logic             long_seen_r;
    logic             rep_hit_s;
    assign rep_hit_s = (ms_cnt_s >= REP_LIM);
`endif

    assign rise_s     = pin_in & ~pin_prev_r;
    assign fall_s     = ~pin_in & pin_prev_r;
    assign long_hit_s = (ms_cnt_s >= LONG_LIM);
    assign gap_hit_s  = (ms_cnt_s >= GAP_LIM);

    ms_tick #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .ms_cnt (ms_cnt_s)
    );

    // Next-state and event decision; edges take priority over timeouts.
    always_comb begin
        next_state_s = state_r;
        emit_s       = 1'b0;
        emit_code_s  = EVT_SINGLE;
        rep_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    next_state_s = ST_PRESS1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (fall_s) begin
                    next_state_s = ST_GAP;
                end else if (long_hit_s) begin
                    next_state_s = ST_WAIT_REL;
                    emit_s       = 1'b1;
                    emit_code_s  = EVT_LONG;
                end else begin
                    next_state_s = ST_PRESS1;
                end
            end
            ST_GAP: begin
                if (rise_s) begin
                    next_state_s = ST_WAIT_REL;
                    emit_s       = 1'b1;
                    emit_code_s  = EVT_DOUBLE;
                end else if (gap_hit_s) begin
                    next_state_s = ST_IDLE;
                    emit_s       = 1'b1;
                    emit_code_s  = EVT_SINGLE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_WAIT_REL: begin
                if (fall_s) begin
                    next_state_s = ST_IDLE;
`ifdef BTN_EVT_REPEAT_EN
                end else if (long_seen_r && rep_hit_s) begin
                    next_state_s = ST_WAIT_REL;
                    emit_s       = 1'b1;
                    emit_code_s  = EVT_REPEAT;
                    rep_clr_s    = 1'b1;
`endif
                end else begin
                    next_state_s = ST_WAIT_REL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign clr_s  = rep_clr_s | (next_state_s != state_r);
    assign load_s = emit_s & evt_can_load(evt_valid, evt_ready);

    // State, edge history and the registered event port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pin_prev_r <= 1'b1;
            held       <= 1'b0;
            evt_valid  <= 1'b0;
            evt_code   <= 2'b00;
            evt_drop   <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            long_seen_r <= 1'b0;
`endif
        end else begin
            state_r    <= next_state_s;
            pin_prev_r <= pin_in;
            held       <= pin_in;
            evt_drop   <= emit_s & ~load_s;
            if (load_s) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code_s;
            end else if (evt_valid & evt_ready) begin
                evt_valid <= 1'b0;
                evt_code  <= evt_code;
            end else begin
                evt_valid <= evt_valid;
                evt_code  <= evt_code;
            end
`ifdef BTN_EVT_REPEAT_EN
            // Only a press that reached LONG may auto-repeat in WAIT_REL.
            if (state_r == ST_IDLE) begin
                long_seen_r <= 1'b0;
            end else if (emit_s && (emit_code_s == EVT_LONG)) begin
                long_seen_r <= 1'b1;
            end else begin
                long_seen_r <= long_seen_r;
            end
`endif
        end
    end

endmodule
